dmux_4way_dispatcher: RTL and testbench

Sequencing controller for the 4-way demultiplexer datapath. It accepts a valid/ready word stream and holds each word in a one-entry buffer. It distributes words across four output channels in round-robin order, and drives the 2-bit `sel` that steers the demux. It sits between a single producer and four consumer lanes, such as the four RAM banks or the four register-file write ports.

---
 rtl/dmux_dispatch_pkg.sv | 19 +
 rtl/dmux_4way_gate.sv | 23 ++
 rtl/dmux_4way_dispatcher.sv | 130 +++++++++++++
 tb/tb_dmux_4way_dispatcher.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmux_dispatch_pkg.sv
// ---------------------------------------------------------------------------
// dmux_dispatch_pkg
// Shared definitions for the 4-way demux dispatcher:
//   - FSM state encoding (ST_EMPTY / ST_FULL) for the one-entry word buffer
//   - channel count N_CH and select width SEL_W
// No ports (package).
// ---------------------------------------------------------------------------
package dmux_dispatch_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  // One-entry buffer state
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  typedef logic [SEL_W-1:0] ch_idx_t;

endpackage

// File: rtl/dmux_4way_gate.sv
// ---------------------------------------------------------------------------
// dmux_4way_gate
// Purely combinational 1-to-4 demultiplexer of a single bit.
// Ports:
//   in      : bit to steer
//   sel[1:0]: destination index (0 -> a, 1 -> b, 2 -> c, 3 -> d)
//   a,b,c,d : outputs; only the selected one can be high
// ---------------------------------------------------------------------------
module dmux_4way_gate (
  input  logic       in,
  input  logic [1:0] sel,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d
);

  assign a = in & (sel == 2'd0);
  assign b = in & (sel == 2'd1);
  assign c = in & (sel == 2'd2);
  assign d = in & (sel == 2'd3);

endmodule

// File: rtl/dmux_4way_dispatcher.sv
// ---------------------------------------------------------------------------
// dmux_4way_dispatcher
// Accepts a valid/ready word stream into a one-entry buffer and hands each
// word to exactly one of four output channels in round-robin order. The
// buffered word is broadcast on out_data; out_valid is one-hot and sel drives
// the external demux select.
//
// Ports:
//   clk           : clock, rising edge
//   rst_n         : synchronous active-low reset
//   in_valid      : producer has a word
//   in_ready      : dispatcher accepts a word this cycle
//   in_data       : producer word (WIDTH bits)
//   out_valid[3:0]: one-hot per-channel valid
//   out_ready[3:0]: per-channel ready
//   out_data      : buffered word, broadcast to all channels
//   sel[1:0]      : current destination channel
//
// Configuration macro: DMUX_DISPATCH_SKIP_EN
//   undefined : strict round-robin, waits on a stalled channel
//   defined   : work-conserving, skips to the next ready channel
// ---------------------------------------------------------------------------
module dmux_4way_dispatcher
  import dmux_dispatch_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [N_CH-1:0]  out_valid,
  input  logic [N_CH-1:0]  out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SEL_W-1:0] sel
);

  logic [0:0]       state_reg;
  logic [0:0]       state_next;
  ch_idx_t          ptr_reg;
  ch_idx_t          ptr_next;
  logic [WIDTH-1:0] data_reg;

  ch_idx_t          dest;
  logic             full;
  logic [N_CH-1:0]  gate_vec;
  logic             in_fire;
  logic             out_fire;

  assign full = (state_reg == ST_FULL);

`ifdef DMUX_DISPATCH_SKIP_EN
  // First ready channel searching cyclically from start. Scanning from the
  // far end backwards lets the nearest ready channel overwrite the result.
  // Falls back to start when nothing is ready.
  function automatic ch_idx_t first_ready(input ch_idx_t start,
                                          input logic [N_CH-1:0] rdy);
    ch_idx_t res;
    ch_idx_t idx;
    res = start;
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx = start + ch_idx_t'(k);
      if (rdy[idx]) res = idx;
    end
    return res;
  endfunction

  assign dest = first_ready(ptr_reg, out_ready);
`else
  assign dest = ptr_reg;
`endif

  dmux_4way_gate u_gate (
    .in  (full),
    .sel (dest),
    .a   (gate_vec[0]),
    .b   (gate_vec[1]),
    .c   (gate_vec[2]),
    .d   (gate_vec[3])
  );

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_valid
`ifdef DMUX_DISPATCH_SKIP_EN
      // Only offer the word to a channel that can take it right now.
      assign out_valid[gi] = gate_vec[gi] & out_ready[gi];
`else
      assign out_valid[gi] = gate_vec[gi];
`endif
    end
  endgenerate

  assign out_fire = |(out_valid & out_ready);
  // Refill in the same cycle the held word leaves.
  assign in_ready = ~full | out_fire;
  assign in_fire  = in_valid & in_ready;

  assign sel      = full ? dest : ptr_reg;
  assign out_data = data_reg;

  always_comb begin
    state_next = state_reg;
    if (in_fire)
      state_next = ST_FULL;
    else if (out_fire)
      state_next = ST_EMPTY;
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (out_fire)
      ptr_next = dest + ch_idx_t'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_EMPTY;
      ptr_reg   <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      if (in_fire)
        data_reg <= in_data;
    end
  end

endmodule

// File: tb/tb_dmux_4way_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_dmux_4way_dispatcher
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a transaction-level model (one-slot buffer + round-robin pointer).
// ---------------------------------------------------------------------------
module tb_dmux_4way_dispatcher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [15:0] out_data;
  logic [1:0]  sel;

  int tests_run    = 0;
  int tests_failed = 0;

  dmux_4way_dispatcher #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sel       (sel)
  );

  always #5 clk = ~clk;

  // Reference model: a one-word holding slot and the next channel in turn.
  bit          m_full = 1'b0;
  logic [15:0] m_data = '0;
  int          m_ptr  = 0;
  int          m_delivered = 0;
  int          dut_delivered = 0;

  // Expected / observed values for the most recent cycle
  logic [3:0]  exp_ov, act_ov;
  logic [1:0]  exp_sel, act_sel;
  logic        exp_ir, act_ir;
  logic [15:0] exp_data, act_data;

  function automatic void model_eval(input logic [3:0] r,
                                     output logic [3:0] ov,
                                     output logic [1:0] s,
                                     output logic ir,
                                     output logic ofire,
                                     output int dst);
    bit found;
    found = 1'b0;
    dst   = m_ptr;
`ifdef DMUX_DISPATCH_SKIP_EN
    for (int k = 0; k < 4; k++) begin
      if (!found && r[(m_ptr + k) % 4]) begin
        dst   = (m_ptr + k) % 4;
        found = 1'b1;
      end
    end
`else
    found = 1'b1;
`endif
    ov = 4'b0000;
    if (m_full && found) ov[dst] = 1'b1;
    ofire = ((ov & r) != 4'b0000);
    s  = m_full ? 2'(dst) : 2'(m_ptr);
    ir = !m_full || ofire;
  endfunction

  // Drive one cycle of stimulus, capture DUT outputs on the falling edge,
  // advance the model at the rising edge. Called at posedge+1.
  task automatic do_cycle(input logic v, input logic [15:0] d, input logic [3:0] r);
    logic ofire;
    int   dst;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(negedge clk);
    model_eval(r, exp_ov, exp_sel, exp_ir, ofire, dst);
    exp_data = m_data;
    act_ov   = out_valid;
    act_sel  = sel;
    act_ir   = in_ready;
    act_data = out_data;
    if (rst_n && ((act_ov & r) != 4'b0000)) begin
      dut_delivered++;
      $display("[TB] word %h -> channel sel=%0d", act_data, act_sel);
    end
    @(posedge clk);
    if (!rst_n) begin
      m_full = 1'b0;
      m_data = '0;
      m_ptr  = 0;
    end else begin
      if (ofire) begin
        m_ptr = (dst + 1) % 4;
        m_delivered++;
      end
      if (v && exp_ir) begin
        m_data = d;
        m_full = 1'b1;
      end else if (ofire) begin
        m_full = 1'b0;
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    do_cycle(1'b0, 16'h0, 4'b0000);
    do_cycle(1'b0, 16'h0, 4'b0000);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    do_cycle(1'b0, 16'h0, 4'b0000);
    do_cycle(1'b0, 16'h0, 4'b0000);
    rst_n = 1'b1;
    do_cycle(1'b0, 16'h0, 4'b1111);
    tests_run++;
    if (act_ov !== 4'b0000 || act_sel !== 2'd0 || act_ir !== 1'b1 || act_data !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_values: ov=%b sel=%0d ir=%b data=%h, want ov=0000 sel=0 ir=1 data=0000",
               act_ov, act_sel, act_ir, act_data);
    end
  endtask

  task automatic test_single_word();
    apply_reset();
    do_cycle(1'b1, 16'h00A5, 4'b1111);
    tests_run++;
    if (act_ir !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_accept: in_ready=%b, want 1", act_ir);
    end
    do_cycle(1'b0, 16'h0, 4'b1111);
    tests_run++;
    if (act_ov !== 4'b0001 || act_data !== 16'h00A5 || act_sel !== 2'd0) begin
      tests_failed++;
      $display("FAIL single_present: ov=%b data=%h sel=%0d, want ov=0001 data=00a5 sel=0",
               act_ov, act_data, act_sel);
    end
    do_cycle(1'b0, 16'h0, 4'b1111);
    tests_run++;
    if (act_ov !== 4'b0000 || act_sel !== 2'd1 || act_data !== 16'h00A5) begin
      tests_failed++;
      $display("FAIL single_after: ov=%b sel=%0d data=%h, want ov=0000 sel=1 data=00a5",
               act_ov, act_sel, act_data);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] want [5];
    want[0] = 4'b0001; want[1] = 4'b0010; want[2] = 4'b0100;
    want[3] = 4'b1000; want[4] = 4'b0001;
    apply_reset();
    do_cycle(1'b1, 16'd1, 4'b1111);
    tests_run++;
    if (act_ir !== 1'b1) begin
      tests_failed++;
      $display("FAIL rr_ready_0: in_ready=%b, want 1", act_ir);
    end
    for (int i = 0; i < 5; i++) begin
      do_cycle(i < 4, 16'(i + 2), 4'b1111);
      tests_run++;
      if (act_ov !== want[i] || act_data !== 16'(i + 1) || act_ir !== 1'b1) begin
        tests_failed++;
        $display("FAIL rr_word%0d: ov=%b data=%h ir=%b, want ov=%b data=%h ir=1",
                 i + 1, act_ov, act_data, act_ir, want[i], 16'(i + 1));
      end
    end
  endtask

`ifndef DMUX_DISPATCH_SKIP_EN
  task automatic test_stall_strict();
    apply_reset();
    do_cycle(1'b1, 16'hBEE1, 4'b1110);
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b1, 16'hBEE2, 4'b1110);
      tests_run++;
      if (act_ov !== 4'b0001 || act_ir !== 1'b0 || act_data !== 16'hBEE1) begin
        tests_failed++;
        $display("FAIL stall_hold%0d: ov=%b ir=%b data=%h, want ov=0001 ir=0 data=bee1",
                 i, act_ov, act_ir, act_data);
      end
    end
    do_cycle(1'b1, 16'hBEE2, 4'b1111);
    tests_run++;
    if (act_ov !== 4'b0001 || act_ir !== 1'b1 || act_data !== 16'hBEE1) begin
      tests_failed++;
      $display("FAIL stall_release: ov=%b ir=%b data=%h, want ov=0001 ir=1 data=bee1",
               act_ov, act_ir, act_data);
    end
    do_cycle(1'b0, 16'h0, 4'b1111);
    tests_run++;
    if (act_ov !== 4'b0010 || act_sel !== 2'd1 || act_data !== 16'hBEE2) begin
      tests_failed++;
      $display("FAIL stall_word2: ov=%b sel=%0d data=%h, want ov=0010 sel=1 data=bee2",
               act_ov, act_sel, act_data);
    end
  endtask
`else
  task automatic test_skip();
    apply_reset();
    do_cycle(1'b1, 16'h5A5A, 4'b0100);
    do_cycle(1'b0, 16'h0, 4'b0100);
    tests_run++;
    if (act_ov !== 4'b0100 || act_sel !== 2'd2 || act_data !== 16'h5A5A) begin
      tests_failed++;
      $display("FAIL skip_dest: ov=%b sel=%0d data=%h, want ov=0100 sel=2 data=5a5a",
               act_ov, act_sel, act_data);
    end
    do_cycle(1'b0, 16'h0, 4'b0000);
    tests_run++;
    if (act_ov !== 4'b0000 || act_sel !== 2'd3) begin
      tests_failed++;
      $display("FAIL skip_ptr: ov=%b sel=%0d, want ov=0000 sel=3", act_ov, act_sel);
    end
  endtask

  task automatic test_skip_none();
    do_cycle(1'b1, 16'h7777, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b1, 16'h8888, 4'b0000);
      tests_run++;
      if (act_ov !== 4'b0000 || act_ir !== 1'b0 || act_data !== 16'h7777) begin
        tests_failed++;
        $display("FAIL skip_none%0d: ov=%b ir=%b data=%h, want ov=0000 ir=0 data=7777",
                 i, act_ov, act_ir, act_data);
      end
    end
    do_cycle(1'b0, 16'h0, 4'b0001);
    tests_run++;
    if (act_ov !== 4'b0001 || act_data !== 16'h7777) begin
      tests_failed++;
      $display("FAIL skip_none_release: ov=%b data=%h, want ov=0001 data=7777", act_ov, act_data);
    end
  endtask
`endif

  task automatic test_reset_mid();
    int seen;
    apply_reset();
    do_cycle(1'b1, 16'hDEAD, 4'b0000);
    do_cycle(1'b0, 16'h0, 4'b0000);
    tests_run++;
    if (act_ir !== 1'b0 || act_data !== 16'hDEAD) begin
      tests_failed++;
      $display("FAIL midrst_full: ir=%b data=%h, want ir=0 data=dead", act_ir, act_data);
    end
    rst_n = 1'b0;
    do_cycle(1'b0, 16'h0, 4'b0000);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      do_cycle(1'b0, 16'h0, 4'b1111);
      if (act_ov != 4'b0000) seen++;
      if (i == 0) begin
        tests_run++;
        if (act_ov !== 4'b0000 || act_sel !== 2'd0 || act_ir !== 1'b1) begin
          tests_failed++;
          $display("FAIL midrst_state: ov=%b sel=%0d ir=%b, want ov=0000 sel=0 ir=1",
                   act_ov, act_sel, act_ir);
        end
      end
    end
    tests_run++;
    if (seen !== 0) begin
      tests_failed++;
      $display("FAIL midrst_leak: %0d cycles with out_valid, want 0", seen);
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    int base_m, base_d;
    apply_reset();
    base_m = m_delivered;
    base_d = dut_delivered;
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 79) != 0);
      for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 3) != 0);
      do_cycle(($urandom_range(0, 2) != 0), 16'($urandom), r);
      tests_run++;
      if (act_ov !== exp_ov || act_sel !== exp_sel || act_ir !== exp_ir || act_data !== exp_data) begin
        tests_failed++;
        $display("FAIL rand_cycle%0d: ov=%b sel=%0d ir=%b data=%h, want ov=%b sel=%0d ir=%b data=%h",
                 i, act_ov, act_sel, act_ir, act_data, exp_ov, exp_sel, exp_ir, exp_data);
      end
    end
    rst_n = 1'b1;
    tests_run++;
    if ((dut_delivered - base_d) !== (m_delivered - base_m)) begin
      tests_failed++;
      $display("FAIL rand_count: delivered=%0d, want %0d",
               dut_delivered - base_d, m_delivered - base_m);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_word();
    test_round_robin();
`ifndef DMUX_DISPATCH_SKIP_EN
    test_stall_strict();
`else
    test_skip();
    test_skip_none();
`endif
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
